weight_display_driver: RTL
==========================

WEIGHT_DISPLAY_DRIVER -- requirements
Module: weight_display_driver

Interface
REQ-001 SHALL have parameter UPDATE_DIV, default 5_000_000, clk cycles between value samples (10 Hz at 50 MHz).
REQ-002 SHALL have parameter REFRESH_DIV, default 50_000, clk cycles each digit is driven (1 ms).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port CALIBRATED_OUTPUT, input, 25, bit 24 = sign (1 = negative), [23:0] = unsigned magnitude.
REQ-006 SHALL have port DP_LOC, input, 3, digit index carrying the decimal point; 0 = no point.
REQ-007 SHALL have port SEG, output, 7, segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port DP, output, 1, decimal point, active-low.
REQ-009 SHALL have port AN, output, 8, digit enables, one-hot active-low; AN[0] = rightmost digit.
REQ-010 SHALL have port BUSY, output, 1, high while a conversion is in progress.

Function
REQ-011 SHALL assert a sample tick every UPDATE_DIV cycles from a free-running counter that wraps at UPDATE_DIV-1.
REQ-012 SHALL implement conversion FSM states IDLE, LOAD, SHIFT, FORMAT.
- IDLE->LOAD on tick.
- LOAD->SHIFT after 1 cycle.
- SHIFT->FORMAT after exactly 24 cycles.
- FORMAT->IDLE after 1 cycle.
REQ-013 SHALL, in LOAD, capture CALIBRATED_OUTPUT and DP_LOC; later input changes SHALL NOT affect the conversion in flight.
REQ-014 SHALL, in SHIFT, run shift-add-3 double dabble on the 24-bit magnitude, producing 8 BCD digits; 16,777,215 is the maximum.
REQ-015 SHALL, in FORMAT, write all 8 digit codes and the dp position into the display buffer in one cycle; the buffer SHALL never hold a partial result.
REQ-016 SHALL have latency tick -> display buffer updated = 26 cycles; BUSY SHALL be high in LOAD, SHIFT and FORMAT.
REQ-017 SHALL ignore a tick arriving while BUSY; no queueing.
REQ-018 SHALL apply leading-zero blanking to digits above max(DP_LOC,0); digit DP_LOC and all digits below it SHALL always be shown, so 0 with DP_LOC=4 reads "0.0000".
REQ-019 SHALL light DP only on digit index DP_LOC when DP_LOC != 0.
REQ-020 SHALL, when the sign bit is set and the value is displayable, place '-' (segment g only) in the digit immediately left of the most significant shown digit.
REQ-021 SHALL show all eight digits as '-' with DP off when the sign bit is set and magnitude >= 10,000,000 (overflow).
REQ-022 SHALL treat DP_LOC values 5..7 as legal and place the point accordingly.
REQ-023 SHALL, in the multiplexer, hold each digit for REFRESH_DIV cycles, then advance the digit index 0->1->...->7->0.
REQ-024 SHALL keep AN one-hot low at all times; SEG, DP and AN SHALL be registered and change in the same cycle.
REQ-025 SHALL drive blank digits as SEG = 7'h7F and DP = 1 while AN remains active.

Reset
REQ-026 SHALL, while rst is high at a clk edge, reset as follows:
- FSM -> IDLE; BUSY = 0.
- Both counters -> 0.
- Display buffer -> all blank, no dp.
- Digit index -> 0.
- SEG = 7'h7F, DP = 1, AN = 8'hFE.
REQ-027 SHALL abandon any conversion in progress when rst is asserted; no buffer write SHALL follow.
REQ-028 SHALL produce the first tick UPDATE_DIV cycles after rst deasserts.

Structure
REQ-029 SHALL place the following in a shared package weight_display_pkg:
- FSM state enum.
- NUM_DIGITS = 8.
- MAG_WIDTH = 24.
- Seven-segment constants for 0-9, MINUS and BLANK.
REQ-030 SHALL isolate double dabble in sub-module bin_to_bcd_seq, with ports start, 24-bit bin, 32-bit bcd and done, instantiated once.

Verification (UPDATE_DIV=100, REFRESH_DIV=4)
REQ-031 SHALL cover: CALIBRATED_OUTPUT=123456, DP_LOC=4 -> digits 5..0 = 1,2,3,4,5,6; DP on digit 4; digits 7,6 blank; reads "12.3456".
REQ-032 SHALL cover: sign=1, magnitude=50000, DP_LOC=4 -> "-5.0000"; '-' on digit 5; DP on digit 4.
REQ-033 SHALL cover: magnitude=0, DP_LOC=4 -> "0.0000"; magnitude=16,777,215, DP_LOC=4, positive -> "1677.7215".
REQ-034 SHALL cover: sign=1, magnitude=12,000,000 -> all eight digits '-', DP off.
REQ-035 SHALL cover: change input on cycle 10 of SHIFT -> displayed value is the LOAD-time input; buffer updates exactly 26 cycles after tick.
REQ-036 SHALL cover: assert rst during SHIFT -> BUSY=0 next cycle, buffer stays blank, AN=8'hFE; next update at UPDATE_DIV after release.

Source files
------------

// File: rtl/weight_display_pkg.sv
// Shared types and constants for the weight display driver: conversion FSM
// states, digit/magnitude widths and active-low seven-segment codes.
package weight_display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      FORMAT
   } conv_state_e;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned MAG_WIDTH  = 24;
   localparam int unsigned BCD_WIDTH  = 4 * NUM_DIGITS;

   // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/weight_display_bin_to_bcd_seq.sv
// Sequential shift-add-3 (double dabble) converter: one bit per cycle,
// MAG_WIDTH cycles after start. done is high during the final shift cycle.
module bin_to_bcd_seq
   import weight_display_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [MAG_WIDTH-1:0] bin,
   output logic [BCD_WIDTH-1:0] bcd,
   output logic                 done
);

   logic [MAG_WIDTH-1:0] bin_q, bin_d;
   logic [BCD_WIDTH-1:0] bcd_q, bcd_d;
   logic [BCD_WIDTH-1:0] adj;
   logic [4:0]           cnt_q, cnt_d;
   logic                 run_q, run_d;

   always_comb begin
      adj = bcd_q;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end

      bin_d = bin_q;
      bcd_d = bcd_q;
      cnt_d = cnt_q;
      run_d = run_q;
      done  = 1'b0;

      if (start) begin
         bin_d = bin;
         bcd_d = '0;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         bcd_d = {adj[BCD_WIDTH-2:0], bin_q[MAG_WIDTH-1]};
         bin_d = {bin_q[MAG_WIDTH-2:0], 1'b0};
         cnt_d = cnt_q + 5'd1;
         if (cnt_q == 5'(MAG_WIDTH - 1)) begin
            run_d = 1'b0;
            done  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign bcd = bcd_q;

endmodule

// File: rtl/weight_display_driver.sv
// Samples a signed 24-bit weight at a fixed rate, converts it to decimal and
// scans the formatted result across an 8-digit multiplexed 7-segment display.
module weight_display_driver
   import weight_display_pkg::*;
#(
   parameter int unsigned UPDATE_DIV  = 5_000_000,
   parameter int unsigned REFRESH_DIV = 50_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [24:0] CALIBRATED_OUTPUT,
   input  logic [2:0]  DP_LOC,
   output logic [6:0]  SEG,
   output logic        DP,
   output logic [7:0]  AN,
   output logic        BUSY
);

   localparam int unsigned UW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
   localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   conv_state_e state_q, state_d;

   logic [UW-1:0] upd_cnt_q, upd_cnt_d;
   logic          tick;

   logic          sign_q, sign_d;
   logic [2:0]    dp_loc_q, dp_loc_d;
   logic          bcd_start;
   logic          bcd_done;
   logic [BCD_WIDTH-1:0] bcd;

   logic [6:0]            buf_seg_q [NUM_DIGITS];
   logic [6:0]            buf_seg_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] buf_dp_q, buf_dp_d;

   logic [6:0]            fmt_seg [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] fmt_dp;
   logic [2:0]            msd;
   logic [2:0]            top;
   logic                  ovf;

   logic [RW-1:0] ref_cnt_q, ref_cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [7:0]    an_q, an_d;

   bin_to_bcd_seq u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (bcd_start),
      .bin   (CALIBRATED_OUTPUT[MAG_WIDTH-1:0]),
      .bcd   (bcd),
      .done  (bcd_done)
   );

   assign tick = (upd_cnt_q == UW'(UPDATE_DIV - 1));

   always_comb begin
      upd_cnt_d = tick ? '0 : upd_cnt_q + UW'(1);
   end

   // top is the highest digit that must be shown; a negative value needs
   // one more position for the sign, otherwise it is an overflow.
   always_comb begin
      msd = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] != 4'd0) msd = 3'(i);
      end
      top = (dp_loc_q > msd) ? dp_loc_q : msd;
      ovf = sign_q && ((bcd[BCD_WIDTH-1 -: 4] != 4'd0) || (top == 3'd7));

      fmt_dp = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         fmt_seg[i] = SEG_BLANK;
         if (ovf) begin
            fmt_seg[i] = SEG_MINUS;
         end else if (i <= 32'(top)) begin
            fmt_seg[i] = digit_to_seg(bcd[4*i +: 4]);
         end else if (sign_q && (i == 32'(top) + 1)) begin
            fmt_seg[i] = SEG_MINUS;
         end
         if (!ovf && (dp_loc_q != 3'd0) && (i == 32'(dp_loc_q))) begin
            fmt_dp[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      dp_loc_d  = dp_loc_q;
      buf_seg_d = buf_seg_q;
      buf_dp_d  = buf_dp_q;
      bcd_start = 1'b0;

      case (state_q)
         IDLE: begin
            if (tick) state_d = LOAD;
         end
         LOAD: begin
            bcd_start = 1'b1;
            sign_d    = CALIBRATED_OUTPUT[MAG_WIDTH];
            dp_loc_d  = DP_LOC;
            state_d   = SHIFT;
         end
         SHIFT: begin
            if (bcd_done) state_d = FORMAT;
         end
         FORMAT: begin
            buf_seg_d = fmt_seg;
            buf_dp_d  = fmt_dp;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if (ref_cnt_q == RW'(REFRESH_DIV - 1)) begin
         ref_cnt_d = '0;
         idx_d     = idx_q + 3'd1;
      end else begin
         ref_cnt_d = ref_cnt_q + RW'(1);
         idx_d     = idx_q;
      end
      seg_d = buf_seg_q[idx_q];
      dp_d  = ~buf_dp_q[idx_q];
      an_d  = ~(8'd1 << idx_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         upd_cnt_q <= '0;
         sign_q    <= 1'b0;
         dp_loc_q  <= '0;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) buf_seg_q[i] <= SEG_BLANK;
         buf_dp_q  <= '0;
         ref_cnt_q <= '0;
         idx_q     <= '0;
         seg_q     <= SEG_BLANK;
         dp_q      <= 1'b1;
         an_q      <= 8'hFE;
      end else begin
         state_q   <= state_d;
         upd_cnt_q <= upd_cnt_d;
         sign_q    <= sign_d;
         dp_loc_q  <= dp_loc_d;
         buf_seg_q <= buf_seg_d;
         buf_dp_q  <= buf_dp_d;
         ref_cnt_q <= ref_cnt_d;
         idx_q     <= idx_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
      end
   end

   assign SEG  = seg_q;
   assign DP   = dp_q;
   assign AN   = an_q;
   assign BUSY = (state_q != IDLE);

endmodule
